// File: rtl/idct_transpose_buf.sv
// rtl/idct_transpose_buf.sv - ping-pong 8x8 transpose buffer between row and column IDCT passes
// Rows are written into one bank while the other bank is read out column by column.
module idct_transpose_buf #(
   parameter int W = 9,
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           row_valid,
   output logic           row_ready,
   input  logic [N*W-1:0] row_in,
   output logic           col_valid,
   input  logic           col_ready,
   output logic [N*W-1:0] col_out,
   output logic           col_last,
   output logic [1:0]     blocks_buffered
);

   logic [W-1:0] mem [2][N][N];

   logic       wb;
   logic       rb;
   logic [2:0] wr_cnt;
   logic [2:0] rd_cnt;
   logic [1:0] full;
   logic [1:0] full_nxt;
   logic       wr_en;
   logic       rd_en;

   assign row_ready       = !full[wb];
   assign col_valid       = full[rb];
   assign wr_en           = row_valid && row_ready;
   assign rd_en           = col_valid && col_ready;
   assign col_last        = col_valid && (rd_cnt == 3'd7);
   assign blocks_buffered = {1'b0, full[0]} + {1'b0, full[1]};

   // Storage is deliberately not reset; the full flags alone decide what is readable.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int c = 0; c < N; c++) begin
            mem[wb][wr_cnt][c] <= row_in[(N-1-c)*W +: W];
         end
      end
   end

   // Set and clear always target different banks, so both may apply in one cycle.
   always_comb begin
      full_nxt = full;
      if (wr_en && (wr_cnt == 3'd7)) begin
         full_nxt[wb] = 1'b1;
      end
      if (rd_en && (rd_cnt == 3'd7)) begin
         full_nxt[rb] = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb     <= 1'b0;
         rb     <= 1'b0;
         wr_cnt <= 3'd0;
         rd_cnt <= 3'd0;
         full   <= 2'b00;
      end else begin
         if (wr_en) begin
            wr_cnt <= wr_cnt + 3'd1;
            if (wr_cnt == 3'd7) begin
               wb <= ~wb;
            end
         end
         if (rd_en) begin
            rd_cnt <= rd_cnt + 3'd1;
            if (rd_cnt == 3'd7) begin
               rb <= ~rb;
            end
         end
         full <= full_nxt;
      end
   end

   always_comb begin
      col_out = '0;
      if (col_valid) begin
         for (int r = 0; r < N; r++) begin
            col_out[(N-1-r)*W +: W] = mem[rb][r][rd_cnt];
         end
      end
   end

endmodule

// File: tb/tb_idct_transpose_buf.sv
// tb/tb_idct_transpose_buf.sv - directed self-checking bench for idct_transpose_buf
module tb_idct_transpose_buf;

   logic        clk;
   logic        rst_n;
   logic        row_valid;
   logic        row_ready;
   logic [71:0] row_in;
   logic        col_valid;
   logic        col_ready;
   logic [71:0] col_out;
   logic        col_last;
   logic [1:0]  blocks_buffered;

   int n_tests = 0;
   int n_fail  = 0;

   idct_transpose_buf #(.W(9), .N(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .row_valid       (row_valid),
      .row_ready       (row_ready),
      .row_in          (row_in),
      .col_valid       (col_valid),
      .col_ready       (col_ready),
      .col_out         (col_out),
      .col_last        (col_last),
      .blocks_buffered (blocks_buffered)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // element c of row r = base + r*8 + c, truncated to 9 bits
   function automatic logic [71:0] mk_row(input int base, input int r);
      logic [71:0] v;
      for (int c = 0; c < 8; c++) v[(7-c)*9 +: 9] = 9'(base + r*8 + c);
      return v;
   endfunction

   function automatic logic [71:0] mk_col(input int base, input int k);
      logic [71:0] v;
      for (int r = 0; r < 8; r++) v[(7-r)*9 +: 9] = 9'(base + r*8 + k);
      return v;
   endfunction

   function automatic logic [71:0] cb_row(input int r);
      logic [71:0] v;
      for (int c = 0; c < 8; c++) v[(7-c)*9 +: 9] = ((r + c) % 2 == 1) ? 9'h100 : 9'h1FF;
      return v;
   endfunction

   function automatic logic [71:0] cb_col(input int k);
      logic [71:0] v;
      for (int r = 0; r < 8; r++) v[(7-r)*9 +: 9] = ((r + k) % 2 == 1) ? 9'h100 : 9'h1FF;
      return v;
   endfunction

   initial begin
      rst_n     = 1'b0;
      row_valid = 1'b0;
      col_ready = 1'b0;
      row_in    = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_row_ready", 72'(row_ready), 72'd1);
      chk("rst_col_valid", 72'(col_valid), 72'd0);
      chk("rst_col_out", col_out, 72'd0);
      chk("rst_col_last", 72'(col_last), 72'd0);
      chk("rst_bb", 72'(blocks_buffered), 72'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_row_ready", 72'(row_ready), 72'd1);
      chk("idle_col_valid", 72'(col_valid), 72'd0);

      // single block, ramp pattern
      col_ready = 1'b1;
      for (int r = 0; r < 8; r++) begin
         chk("blk_cv_pre", 72'(col_valid), 72'd0);
         row_valid = 1'b1;
         row_in    = mk_row(0, r);
         @(negedge clk);
      end
      row_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("blk_cv", 72'(col_valid), 72'd1);
         chk("blk_col", col_out, mk_col(0, k));
         chk("blk_last", 72'(col_last), 72'(k == 7));
         @(negedge clk);
      end
      chk("blk_cv_end", 72'(col_valid), 72'd0);
      chk("blk_out_end", col_out, 72'd0);
      chk("blk_bb_end", 72'(blocks_buffered), 72'd0);

      // negative-value checkerboard
      for (int r = 0; r < 8; r++) begin
         row_valid = 1'b1;
         row_in    = cb_row(r);
         @(negedge clk);
      end
      row_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("cb_col", col_out, cb_col(k));
         @(negedge clk);
      end
      chk("cb_cv_end", 72'(col_valid), 72'd0);

      // four back-to-back blocks
      for (int t = 0; t <= 40; t++) begin
         if (t < 32) begin
            chk("str_row_ready", 72'(row_ready), 72'd1);
            row_valid = 1'b1;
            row_in    = mk_row((t / 8) * 64, t % 8);
         end else begin
            row_valid = 1'b0;
         end
         chk("str_cv", 72'(col_valid), 72'((t >= 8) && (t < 40)));
         if ((t >= 8) && (t < 40)) begin
            chk("str_col", col_out, mk_col(((t - 8) / 8) * 64, (t - 8) % 8));
            chk("str_last", 72'(col_last), 72'((t - 8) % 8 == 7));
         end
         chk("str_bb_le1", 72'(blocks_buffered <= 2'd1), 72'd1);
         @(negedge clk);
      end

      // backpressure: fill both banks
      col_ready = 1'b0;
      for (int r = 0; r < 16; r++) begin
         chk("bp_fill_ready", 72'(row_ready), 72'd1);
         row_valid = 1'b1;
         row_in    = mk_row((r < 8) ? 100 : 200, r % 8);
         @(negedge clk);
      end
      row_valid = 1'b0;
      chk("bp_bb2", 72'(blocks_buffered), 72'd2);
      chk("bp_ready0", 72'(row_ready), 72'd0);
      chk("bp_cv", 72'(col_valid), 72'd1);
      chk("bp_col0", col_out, mk_col(100, 0));
      row_valid = 1'b1;
      row_in    = mk_row(300, 0);
      @(negedge clk);
      row_valid = 1'b0;
      chk("bp_17th_bb", 72'(blocks_buffered), 72'd2);
      chk("bp_stall_col", col_out, mk_col(100, 0));
      col_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("bp_drain_ready", 72'(row_ready), 72'd0);
         chk("bp_a_col", col_out, mk_col(100, k));
         @(negedge clk);
      end
      chk("bp_ready_back", 72'(row_ready), 72'd1);
      chk("bp_bb1", 72'(blocks_buffered), 72'd1);
      for (int k = 0; k < 8; k++) begin
         chk("bp_b_col", col_out, mk_col(200, k));
         chk("bp_b_last", 72'(col_last), 72'(k == 7));
         @(negedge clk);
      end
      chk("bp_cv_end", 72'(col_valid), 72'd0);
      chk("bp_bb_end", 72'(blocks_buffered), 72'd0);

      // reset with one full bank and a partial second block
      col_ready = 1'b0;
      for (int r = 0; r < 13; r++) begin
         row_valid = 1'b1;
         row_in    = mk_row(400, r % 8);
         @(negedge clk);
      end
      row_valid = 1'b0;
      chk("mr_bb_pre", 72'(blocks_buffered), 72'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_bb", 72'(blocks_buffered), 72'd0);
      chk("mr_cv", 72'(col_valid), 72'd0);
      chk("mr_out", col_out, 72'd0);
      chk("mr_ready", 72'(row_ready), 72'd1);
      @(negedge clk);
      rst_n     = 1'b1;
      col_ready = 1'b1;
      @(negedge clk);
      for (int r = 0; r < 8; r++) begin
         chk("mr_cv_pre", 72'(col_valid), 72'd0);
         row_valid = 1'b1;
         row_in    = mk_row(500, r);
         @(negedge clk);
      end
      row_valid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("mr_col", col_out, mk_col(500, k));
         chk("mr_last", 72'(col_last), 72'(k == 7));
         @(negedge clk);
      end
      for (int t = 0; t < 3; t++) begin
         chk("mr_no_stale", 72'(col_valid), 72'd0);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/idct_transpose_buf.md
Name: idct_transpose_buf

Overview:
- Ping-pong transpose buffer between the row (first-pass) 1-D IDCT and the column (second-pass) 1-D IDCT.
- Accepts eight 8-element row results, one row per transfer, and emits the same 8x8 block column by column.
- Two banks let bank A fill while bank B drains. Sustained rate is one row in and one column out per clock.

Parameters:
- W, 9, width of one element (row-IDCT output sample, two's complement).
- N, 8, elements per row/column and rows/columns per block (fixed at 8; must not be changed).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- row_valid  input  1  row_in holds a valid row.
- row_ready  output  1  buffer can accept a row this cycle.
- row_in  input  N*W (72)  one row; element 0 at [71:63], element 7 at [8:0].
- col_valid  output  1  col_out holds a valid column.
- col_ready  input  1  downstream accepts the column this cycle.
- col_out  output  N*W (72)  one column; row 0 element at [71:63], row 7 element at [8:0].
- col_last  output  1  high with col_valid when col_out is column 7 of the block.
- blocks_buffered  output  2  number of banks currently full (0..2).

Behaviour:
- Storage: two banks of N x N x W registers. Storage contents are not reset.
- State: wb (write bank), wr_cnt[2:0], rb (read bank), rd_cnt[2:0], full[1:0].
- Reset values: wb=0, rb=0, wr_cnt=0, rd_cnt=0, full=00. Outputs after reset:
  - row_ready=1
  - col_valid=0
  - col_out=0
  - col_last=0
  - blocks_buffered=0
- Reset asserted mid-block discards the partial block and both full flags. No column is emitted for it.
- Write side:
  - row_ready = !full[wb].
  - A row is accepted on a rising edge with row_valid && row_ready. It is stored as row wr_cnt of bank wb, then wr_cnt increments.
  - Accepting with wr_cnt==7 sets full[wb], toggles wb and wraps wr_cnt to 0.
  - row_in is ignored when row_ready=0. No data loss and no overwrite of a full bank.
- Read side:
  - col_valid = full[rb].
  - col_out is combinational from bank rb, column rd_cnt: element r of col_out is bank[rb][row r][element rd_cnt].
  - col_out is forced to 0 when col_valid=0.
  - col_last = col_valid && (rd_cnt==7).
  - A column is transferred on a rising edge with col_valid && col_ready, then rd_cnt increments.
  - Transfer with rd_cnt==7 clears full[rb], toggles rb and wraps rd_cnt to 0.
- Simultaneous events:
  - Setting full on one bank and clearing full on the other in the same cycle is legal; both take effect.
  - The same bank cannot be set and cleared in one cycle, because set requires full[wb]=0 and clear requires full[rb]=1.
  - blocks_buffered = full[0] + full[1].
- Latency: col_valid rises the cycle after the 8th row of a block is accepted. column 0 is visible that same cycle.
- Throughput: with row_valid and col_ready held high, no bubbles occur after the first block. Blocks complete every 8 cycles.
- Backpressure:
  - Holding col_ready=0 stalls col_out, which stays stable.
  - Once both banks fill, row_ready drops.
  - row_ready returns the cycle after the draining bank's column 7 transfers.
- Arithmetic: none. Pure data movement, bit-exact, W bits per element, signedness preserved.

Test Plan:
- Reset then idle:
  - Release rst_n -> row_ready=1, col_valid=0, col_out=0, blocks_buffered=0.
  - Hold rst_n low mid-stream -> all of the above immediately.
- Single block transpose:
  - Stimulus: rows where element c of row r = r*8+c (9-bit), rows sent on 8 consecutive cycles, col_ready=1.
  - Response: col_valid rises the cycle after row 7; column k element r = r*8+k.
  - col_last is high only on column 7.
- Negative values:
  - Stimulus: a block of 9'h1FF (-1) and 9'h100 (-256) in a checkerboard.
  - Response: output is the transposed checkerboard, bit-exact.
- Continuous streaming:
  - Stimulus: 4 back-to-back blocks, row_valid=1 and col_ready=1 throughout.
  - Response: row_ready stays 1 throughout; 32 columns emerge contiguously in order; blocks_buffered never exceeds 1.
- Backpressure fill:
  - Stimulus: col_ready=0 while sending 16 rows.
  - Response: blocks_buffered=2 and row_ready=0 after row 16; a 17th row is not accepted.
  - Release col_ready -> row_ready=1 the cycle after the 8th column transfer; the first block emerges before the second.
- Reset mid-block:
  - Stimulus: send 5 rows, pulse rst_n low, then send a fresh 8-row block.
  - Response: only the fresh block is output, with correct transposition; no stale columns.
